// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
package mux8_rr_arbiter_pkg;

    localparam int NUM_REQ       = 8;
    localparam int SEL_W         = 3;
    localparam int MAX_BEATS_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_pick8.sv
// Rotating-priority pick: first requester after Ptr wins, Ptr itself last.
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   win
);

    logic             found;
    logic [SEL_W-1:0] idx;

    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        any = found;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the select of an 8:1 word mux, with bursts
// of up to MAX_BEATS accepted words per grant.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int MAX_BEATS = MAX_BEATS_DEF,
    parameter int CNT_W     = 5
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_REQ-1:0] Req,
    input  logic               Ack,
    output logic [SEL_W-1:0]   Sel,
    output logic [NUM_REQ-1:0] Grant,
    output logic               Valid,
    output logic [CNT_W-1:0]   Beat
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   beat_q, beat_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_win;
    logic [SEL_W-1:0] pick_ptr;
    logic             release_g;

    // On release the pick already sees the updated pointer (the current owner).
    assign pick_ptr = (state_q == GRANT) ? sel_q : ptr_q;

    rr_pick8 u_pick (
        .req (Req),
        .ptr (pick_ptr),
        .any (pick_any),
        .win (pick_win)
    );

    assign release_g = !Req[sel_q] ||
                       (Ack && (beat_q == CNT_W'(MAX_BEATS - 1)));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    sel_d   = pick_win;
                    grant_d = onehot(pick_win);
                    valid_d = 1'b1;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (release_g) begin
                    ptr_d  = sel_q;
                    beat_d = '0;
                    if (pick_any) begin
                        sel_d   = pick_win;
                        grant_d = onehot(pick_win);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end else if (Ack) begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            ptr_q   <= SEL_W'(NUM_REQ - 1);
            sel_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

    assign Sel   = sel_q;
    assign Grant = grant_q;
    assign Valid = valid_q;
    assign Beat  = beat_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench: directed vectors push expected outputs, a negedge
// monitor pops and compares them on the cycle they are due.
module tb_mux8_rr_arbiter;

    logic       Clk;
    logic       Reset;
    logic [7:0] Req;
    logic       Ack;

    logic [2:0] sel0, sel1;
    logic [7:0] grant0, grant1;
    logic       valid0, valid1;
    logic [4:0] beat0, beat1;

    mux8_rr_arbiter #(.MAX_BEATS(4), .CNT_W(5)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Req   (Req),
        .Ack   (Ack),
        .Sel   (sel0),
        .Grant (grant0),
        .Valid (valid0),
        .Beat  (beat0)
    );

    mux8_rr_arbiter #(.MAX_BEATS(1), .CNT_W(5)) dut1 (
        .Clk   (Clk),
        .Reset (Reset),
        .Req   (Req),
        .Ack   (Ack),
        .Sel   (sel1),
        .Grant (grant1),
        .Valid (valid1),
        .Beat  (beat1)
    );

    typedef struct {
        int         cyc;
        int         id;
        logic       v;
        logic [2:0] s;
        logic [7:0] g;
        logic [4:0] b;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: compares every expectation due on this cycle.
    always @(negedge Clk) begin
        logic       av;
        logic [2:0] as;
        logic [7:0] ag;
        logic [4:0] ab;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            av = (e.id == 0) ? valid0 : valid1;
            as = (e.id == 0) ? sel0 : sel1;
            ag = (e.id == 0) ? grant0 : grant1;
            ab = (e.id == 0) ? beat0 : beat1;
            n_vec++;
            if (e.cyc != cyc) begin
                n_err++;
                $display("FAIL stale_vec dut%0d due cyc %0d seen cyc %0d",
                         e.id, e.cyc, cyc);
            end else if (av !== e.v || as !== e.s || ag !== e.g || ab !== e.b) begin
                n_err++;
                $display("FAIL vec dut%0d cyc %0d: got V=%b S=%0d G=%h B=%0d, want V=%b S=%0d G=%h B=%0d",
                         e.id, cyc, av, as, ag, ab, e.v, e.s, e.g, e.b);
            end
        end
    end

    // Drive one cycle of inputs and push the outputs expected after the edge.
    task automatic step(input logic [7:0] r, input logic a, input logic rs,
                        input logic [1:0] ids, input logic v, input logic [2:0] s,
                        input logic [7:0] g, input logic [4:0] b);
        exp_t x;
        Req   = r;
        Ack   = a;
        Reset = rs;
        for (int i = 0; i < 2; i++) begin
            if (ids[i]) begin
                x.cyc = cyc + 1;
                x.id  = i;
                x.v   = v;
                x.s   = s;
                x.g   = g;
                x.b   = b;
                sb.push_back(x);
            end
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1;
        Req   = 8'h00;
        Ack   = 1'b0;

        // 1: reset with all requesting, then requester 0 first
        step(8'hFF, 0, 1, 2'b01, 0, 0, 8'h00, 0);
        step(8'hFF, 0, 1, 2'b01, 0, 0, 8'h00, 0);
        step(8'hFF, 0, 0, 2'b01, 1, 0, 8'h01, 0);
        // 0 withdraws -> back-to-back to 2
        step(8'h24, 0, 0, 2'b01, 1, 2, 8'h04, 0);
        // 2: bursts of 4 alternating 2 and 5
        step(8'h24, 1, 0, 2'b01, 1, 2, 8'h04, 1);
        step(8'h24, 1, 0, 2'b01, 1, 2, 8'h04, 2);
        step(8'h24, 1, 0, 2'b01, 1, 2, 8'h04, 3);
        step(8'h24, 1, 0, 2'b01, 1, 5, 8'h20, 0);
        step(8'h24, 1, 0, 2'b01, 1, 5, 8'h20, 1);
        step(8'h24, 1, 0, 2'b01, 1, 5, 8'h20, 2);
        step(8'h24, 1, 0, 2'b01, 1, 5, 8'h20, 3);
        step(8'h24, 1, 0, 2'b01, 1, 2, 8'h04, 0);
        // 3: requester 3 alone, two beats, then withdraws
        step(8'h08, 0, 0, 2'b01, 1, 3, 8'h08, 0);
        step(8'h08, 1, 0, 2'b01, 1, 3, 8'h08, 1);
        step(8'h08, 1, 0, 2'b01, 1, 3, 8'h08, 2);
        step(8'h00, 0, 0, 2'b01, 0, 3, 8'h00, 0);
        // 5a: Ack while idle is ignored
        step(8'h00, 1, 0, 2'b01, 0, 3, 8'h00, 0);
        step(8'h00, 1, 0, 2'b01, 0, 3, 8'h00, 0);
        // 4: sole requester 6 is re-granted after its burst
        step(8'h40, 0, 0, 2'b01, 1, 6, 8'h40, 0);
        step(8'h40, 1, 0, 2'b01, 1, 6, 8'h40, 1);
        step(8'h40, 1, 0, 2'b01, 1, 6, 8'h40, 2);
        step(8'h40, 1, 0, 2'b01, 1, 6, 8'h40, 3);
        step(8'h40, 1, 0, 2'b01, 1, 6, 8'h40, 0);
        step(8'h40, 1, 0, 2'b01, 1, 6, 8'h40, 1);
        step(8'h40, 1, 0, 2'b01, 1, 6, 8'h40, 2);
        // 5b: reset mid-burst, pointer back to 7 so 0 wins next
        step(8'h40, 1, 1, 2'b11, 0, 0, 8'h00, 0);
        step(8'hFF, 0, 0, 2'b01, 1, 0, 8'h01, 0);
        step(8'hFF, 0, 0, 2'b01, 1, 0, 8'h01, 0);
        // 6: MAX_BEATS=1 instance rotates every Ack
        step(8'hFF, 1, 1, 2'b11, 0, 0, 8'h00, 0);
        step(8'hFF, 1, 0, 2'b10, 1, 0, 8'h01, 0);
        for (int i = 1; i <= 8; i++) begin
            logic [2:0] s;
            s = 3'(i);
            step(8'hFF, 1, 0, 2'b10, 1, s, 8'h01 << s, 0);
        end

        Req = 8'h00;
        Ack = 1'b0;
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge Clk);
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
